// File: rtl/udp_arb_pkg.sv
// Shared constants and helpers for the two-channel UDP transmit arbiter.
package udp_arb_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [LEN_W-1:0] MAX_LEN_DEF = 16'd1472;

  // True on the last cycle of a count of lim cycles; lim=0 behaves as one cycle.
  function automatic logic cnt_expired(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lim);
    return ({1'b0, cnt} + 17'd1) >= {1'b0, lim};
  endfunction

  function automatic logic [BEAT_W-1:0] beats_of(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + 17'd7;
    return sum[BEAT_W+2:3];
  endfunction

  function automatic logic [KEEP_W-1:0] last_keep(input logic [2:0] rem);
    logic [KEEP_W-1:0] k;
    for (int i = 0; i < KEEP_W; i++) begin
      k[i] = (rem == 3'd0) || (3'(i) < rem);
    end
    return k;
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// UDP core transmit handshake: status from the core, request/data toward it.
interface udp_tx_arbiter_if;
  import udp_arb_pkg::*;

  logic                  udp_tx_ready;
  logic                  app_tx_ack;
  logic                  dst_ip_unreachable;
  logic                  app_tx_request;
  logic                  app_tx_data_valid;
  logic                  app_tx_data_last;
  logic [DATA_W-1:0]     app_tx_data;
  logic [KEEP_W-1:0]     app_tx_data_keep;
  logic [LEN_W-1:0]      app_tx_data_length;

  modport master (
    input  udp_tx_ready, app_tx_ack, dst_ip_unreachable,
    output app_tx_request, app_tx_data_valid, app_tx_data_last,
           app_tx_data, app_tx_data_keep, app_tx_data_length
  );

  modport slave (
    output udp_tx_ready, app_tx_ack, dst_ip_unreachable,
    input  app_tx_request, app_tx_data_valid, app_tx_data_last,
           app_tx_data, app_tx_data_keep, app_tx_data_length
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter moving whole packets from two FWFT sources into a UDP core,
// with length screening, ack timeout and an enforced inter-packet gap.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter logic [15:0] GAP_CYCLES  = 16'd20000,
  parameter logic [15:0] ACK_TIMEOUT = 16'd50000,
  parameter logic [15:0] MAX_LEN     = MAX_LEN_DEF
) (
  input  logic                clk_15_625,
  input  logic                core_reset,
  input  logic                ch0_req,
  input  logic [LEN_W-1:0]    ch0_len,
  input  logic [DATA_W-1:0]   ch0_data,
  output logic                ch0_rd,
  output logic                ch0_done,
  output logic                ch0_drop,
  input  logic                ch1_req,
  input  logic [LEN_W-1:0]    ch1_len,
  input  logic [DATA_W-1:0]   ch1_data,
  output logic                ch1_rd,
  output logic                ch1_done,
  output logic                ch1_drop,
  udp_tx_arbiter_if.master    udp,
  output logic                busy
);

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              gnt_q,      gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [BEAT_W-1:0] beats_q,    beats_d;
  logic [BEAT_W-1:0] beat_q,     beat_d;
  logic              req_q,      req_d;
  logic              valid_q,    valid_d;
  logic              last_q,     last_d;
  logic [KEEP_W-1:0] keep_q,     keep_d;
  logic [LEN_W-1:0]  length_q,   length_d;
  logic [1:0]        done_q,     done_d;
  logic [1:0]        drop_q,     drop_d;
  logic              pick_c;

  // Both requesting: the channel not served last wins.
  assign pick_c = (ch0_req && ch1_req) ? ~last_gnt_q : ch1_req;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    len_d      = len_q;
    beats_d    = beats_q;
    beat_d     = '0;
    done_d     = 2'b00;
    drop_d     = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (udp.udp_tx_ready && (ch0_req || ch1_req)) begin
          gnt_d   = pick_c;
          len_d   = pick_c ? ch1_len : ch0_len;
          beats_d = beats_of(len_d);
          if ((len_d == '0) || (len_d > MAX_LEN)) begin
            drop_d[pick_c] = 1'b1;
            last_gnt_d     = pick_c;
            state_d        = ST_GAP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (udp.app_tx_ack) begin
          state_d = ST_DATA;
        end else if (udp.dst_ip_unreachable || cnt_expired(cnt_q, ACK_TIMEOUT)) begin
          drop_d[gnt_q] = 1'b1;
          last_gnt_d    = gnt_q;
          state_d       = ST_GAP;
        end
      end
      ST_DATA: begin
        if (last_q) begin
          done_d[gnt_q] = 1'b1;
          last_gnt_d    = gnt_q;
          state_d       = ST_GAP;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_expired(cnt_q, GAP_CYCLES)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 16'd1;

    // Output registers are loaded from the state being entered.
    req_d    = (state_d == ST_REQ);
    length_d = req_d ? len_d : '0;
    valid_d  = (state_d == ST_DATA);
    last_d   = valid_d && (beat_d == (beats_d - 8'd1));
    keep_d   = !valid_d ? '0 : (last_d ? last_keep(len_d[2:0]) : 8'hFF);
  end

  always_ff @(posedge clk_15_625 or posedge core_reset) begin
    if (core_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      len_q      <= '0;
      beats_q    <= '0;
      beat_q     <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      keep_q     <= '0;
      length_q   <= '0;
      done_q     <= 2'b00;
      drop_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      len_q      <= len_d;
      beats_q    <= beats_d;
      beat_q     <= beat_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      keep_q     <= keep_d;
      length_q   <= length_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  assign udp.app_tx_request     = req_q;
  assign udp.app_tx_data_valid  = valid_q;
  assign udp.app_tx_data_last   = last_q;
  assign udp.app_tx_data_keep   = keep_q;
  assign udp.app_tx_data_length = length_q;
  assign udp.app_tx_data        = gnt_q ? ch1_data : ch0_data;

  assign ch0_rd   = valid_q && !gnt_q;
  assign ch1_rd   = valid_q &&  gnt_q;
  assign ch0_done = done_q[0];
  assign ch1_done = done_q[1];
  assign ch0_drop = drop_q[0];
  assign ch1_drop = drop_q[1];
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: expected beats and outcomes are queued
// when a packet is offered and checked as the arbiter produces them.
module tb_udp_tx_arbiter;
  import udp_arb_pkg::*;

  localparam logic [15:0] GAP = 16'd4;
  localparam logic [15:0] TO  = 16'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch0_req = 1'b0, ch1_req = 1'b0;
  logic [15:0] ch0_len = '0,   ch1_len = '0;
  logic [63:0] ch0_data, ch1_data;
  logic        ch0_rd, ch0_done, ch0_drop, ch1_rd, ch1_done, ch1_drop, busy;
  logic [31:0] ptr0, ptr1;

  always #5 clk = ~clk;

  udp_tx_arbiter_if udp ();

  udp_tx_arbiter #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TO), .MAX_LEN(16'd1472)) dut (
    .clk_15_625(clk), .core_reset(rst),
    .ch0_req(ch0_req), .ch0_len(ch0_len), .ch0_data(ch0_data),
    .ch0_rd(ch0_rd), .ch0_done(ch0_done), .ch0_drop(ch0_drop),
    .ch1_req(ch1_req), .ch1_len(ch1_len), .ch1_data(ch1_data),
    .ch1_rd(ch1_rd), .ch1_done(ch1_done), .ch1_drop(ch1_drop),
    .udp(udp), .busy(busy)
  );

  function automatic logic [63:0] word(input bit ch, input logic [31:0] p);
    return {24'hC4A000, 7'd0, ch, p};
  endfunction

  // FWFT source model: each channel presents a numbered word, advanced on rd.
  assign ch0_data = word(1'b0, ptr0);
  assign ch1_data = word(1'b1, ptr1);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr0 <= '0;
      ptr1 <= '0;
    end else begin
      if (ch0_rd) ptr0 <= ptr0 + 32'd1;
      if (ch1_rd) ptr1 <= ptr1 + 32'd1;
    end
  end

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  rd;
  } beat_t;

  beat_t       bq[$];
  logic [3:0]  oq[$];
  logic [31:0] eptr[2];
  int          n_chk = 0;
  int          n_pass = 0;
  beat_t       mon_e;
  logic [3:0]  mon_code;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Outcome code is {ch1_drop, ch0_drop, ch1_done, ch0_done}.
  task automatic push_pkt(input bit ch, input logic [15:0] len, input bit acked);
    int nb;
    beat_t e;
    if (len == 16'd0 || len > 16'd1472 || !acked) begin
      oq.push_back(ch ? 4'b1000 : 4'b0100);
    end else begin
      nb = (int'(len) + 7) / 8;
      for (int b = 0; b < nb; b++) begin
        e.data = word(ch, eptr[ch]);
        eptr[ch] = eptr[ch] + 32'd1;
        e.last = (b == nb - 1);
        e.keep = (e.last && len[2:0] != 3'd0) ? 8'(8'hFF >> (4'd8 - {1'b0, len[2:0]})) : 8'hFF;
        e.rd   = ch ? 2'b10 : 2'b01;
        bq.push_back(e);
      end
      oq.push_back(ch ? 4'b0010 : 4'b0001);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (udp.app_tx_data_valid) begin
        if (bq.size() == 0) begin
          chk("beat_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = bq.pop_front();
          chk("beat_data", udp.app_tx_data, mon_e.data);
          chk("beat_keep", 64'(udp.app_tx_data_keep), 64'(mon_e.keep));
          chk("beat_last", 64'(udp.app_tx_data_last), 64'(mon_e.last));
          chk("beat_rd", 64'({ch1_rd, ch0_rd}), 64'(mon_e.rd));
        end
      end else if (udp.app_tx_data_last || ch0_rd || ch1_rd) begin
        chk("stray_last_rd", 64'({udp.app_tx_data_last, ch1_rd, ch0_rd}), 64'd0);
      end
      mon_code = {ch1_drop, ch0_drop, ch1_done, ch0_done};
      if (mon_code != 4'd0) begin
        if (oq.size() == 0) chk("pulse_unexpected", 64'(mon_code), 64'd0);
        else                chk("outcome", 64'(mon_code), 64'(oq.pop_front()));
      end
    end
  end

  function automatic logic pulse();
    return ch0_done || ch1_done || ch0_drop || ch1_drop;
  endfunction

  task automatic wait_req(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (udp.app_tx_request) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_req_seen"}, 64'(ok), 64'd1);
  endtask

  // Finds the outcome pulse (checking the present cycle first), then measures
  // how long busy stays high from the first GAP cycle.
  task automatic wait_outcome_gap(input string tag);
    bit ok;
    int g;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pulse()) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_outcome_seen"}, 64'(ok), 64'd1);
    g = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      g++;
    end
    chk({tag, "_gap_len"}, 64'(g), 64'(GAP));
  endtask

  task automatic ack_now();
    udp.app_tx_ack = 1'b1;
    @(posedge clk);
    #1 udp.app_tx_ack = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input bit ch, input logic [15:0] len);
    if (ch) begin ch1_len = len; ch1_req = 1'b1; end
    else    begin ch0_len = len; ch0_req = 1'b1; end
    push_pkt(ch, len, 1'b1);
    wait_req(tag);
    chk({tag, "_length"}, 64'(udp.app_tx_data_length), 64'(len));
    if (ch) ch1_req = 1'b0; else ch0_req = 1'b0;
    ack_now();
    wait_outcome_gap(tag);
  endtask

  task automatic drop_len(input string tag, input bit ch, input logic [15:0] len);
    bit seen;
    seen = 1'b0;
    if (ch) begin ch1_len = len; ch1_req = 1'b1; end
    else    begin ch0_len = len; ch0_req = 1'b1; end
    push_pkt(ch, len, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (udp.app_tx_request) seen = 1'b1;
      if (pulse()) break;
    end
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    chk({tag, "_no_request"}, 64'(seen), 64'd0);
    wait_outcome_gap(tag);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req_valid_last"}, 64'({udp.app_tx_request, udp.app_tx_data_valid,
                                        udp.app_tx_data_last}), 64'd0);
    chk({tag, "_keep_length"}, 64'({udp.app_tx_data_keep, udp.app_tx_data_length}), 64'd0);
    chk({tag, "_ch_strobes"}, 64'({ch1_rd, ch1_done, ch1_drop, ch0_rd, ch0_done, ch0_drop}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bq.delete();
    oq.delete();
    eptr[0] = '0;
    eptr[1] = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
  endtask

  int  n;
  int  v;

  initial begin
    udp.udp_tx_ready       = 1'b0;
    udp.app_tx_ack         = 1'b0;
    udp.dst_ip_unreachable = 1'b0;
    reset_dut();

    // ch0 len=20, ack on the third request cycle.
    @(negedge clk);
    udp.udp_tx_ready = 1'b1;
    ch0_len = 16'd20;
    ch0_req = 1'b1;
    push_pkt(1'b0, 16'd20, 1'b1);
    wait_req("t1");
    ch0_req = 1'b0;
    chk("t1_length", 64'(udp.app_tx_data_length), 64'd20);
    chk("t1_busy", 64'(busy), 64'd1);
    n = 1;
    repeat (2) begin
      @(negedge clk);
      if (udp.app_tx_request) n++;
    end
    ack_now();
    @(negedge clk);
    chk("t1_req_dropped", 64'(udp.app_tx_request), 64'd0);
    chk("t1_req_cycles", 64'(n), 64'd3);
    wait_outcome_gap("t1");
    chk("t1_drained", 64'(bq.size() + oq.size()), 64'd0);

    // Both channels requesting continuously: grants alternate from ch0.
    reset_dut();
    ch0_len = 16'd8;
    ch1_len = 16'd8;
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    push_pkt(1'b0, 16'd8, 1'b1);
    push_pkt(1'b1, 16'd8, 1'b1);
    push_pkt(1'b0, 16'd8, 1'b1);
    push_pkt(1'b1, 16'd8, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_req("t2");
      ack_now();
      wait_outcome_gap("t2");
    end
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    chk("t2_drained", 64'(bq.size() + oq.size()), 64'd0);

    // Unreachable drops; ack together with unreachable sends data.
    ch1_len = 16'd16;
    ch1_req = 1'b1;
    push_pkt(1'b1, 16'd16, 1'b0);
    wait_req("t3a");
    udp.dst_ip_unreachable = 1'b1;
    @(posedge clk);
    #1 udp.dst_ip_unreachable = 1'b0;
    @(negedge clk);
    chk("t3a_req_dropped", 64'(udp.app_tx_request), 64'd0);
    wait_outcome_gap("t3a");
    push_pkt(1'b1, 16'd16, 1'b1);
    wait_req("t3b");
    ch1_req = 1'b0;
    udp.dst_ip_unreachable = 1'b1;
    udp.app_tx_ack = 1'b1;
    @(posedge clk);
    #1;
    udp.dst_ip_unreachable = 1'b0;
    udp.app_tx_ack = 1'b0;
    udp.udp_tx_ready = 1'b0;
    wait_outcome_gap("t3b");
    udp.udp_tx_ready = 1'b1;
    chk("t3_drained", 64'(bq.size() + oq.size()), 64'd0);

    // Ack timeout, then illegal lengths and the largest legal one.
    ch0_len = 16'd64;
    ch0_req = 1'b1;
    push_pkt(1'b0, 16'd64, 1'b0);
    wait_req("t4");
    ch0_req = 1'b0;
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (udp.app_tx_request) n++;
      else break;
    end
    chk("t4_req_cycles", 64'(n), 64'(TO));
    wait_outcome_gap("t4");
    drop_len("t4_len0", 1'b1, 16'd0);
    drop_len("t4_len1500", 1'b0, 16'd1500);
    drop_len("t4_len1473", 1'b0, 16'd1473);
    run_pkt("t4_len1472", 1'b1, 16'd1472);
    run_pkt("t4_len13", 1'b0, 16'd13);
    chk("t4_drained", 64'(bq.size() + oq.size()), 64'd0);

    // Reset during beat 2 of 5 abandons the packet; ch0 wins first afterwards.
    ch0_len = 16'd40;
    ch0_req = 1'b1;
    push_pkt(1'b0, 16'd40, 1'b1);
    wait_req("t5");
    ch0_req = 1'b0;
    ack_now();
    v = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (udp.app_tx_data_valid) v++;
      if (v == 2) break;
    end
    chk("t5_beats_before_reset", 64'(v), 64'd2);
    #2 rst = 1'b1;
    #1 check_quiet("t5_async");
    bq.delete();
    oq.delete();
    eptr[0] = '0;
    eptr[1] = '0;
    repeat (3) @(negedge clk);
    check_quiet("t5_held");
    rst = 1'b0;
    ch0_len = 16'd8;
    ch1_len = 16'd8;
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    push_pkt(1'b0, 16'd8, 1'b1);
    push_pkt(1'b1, 16'd8, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_req("t5_after");
      ack_now();
      wait_outcome_gap("t5_after");
    end
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_drained", 64'(bq.size() + oq.size()), 64'd0);
    chk("end_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, 16'd20000, idle cycles enforced after every packet outcome.
REQ-002 SHALL have parameter ACK_TIMEOUT, 16'd50000, maximum cycles spent waiting for app_tx_ack.
REQ-003 SHALL have parameter MAX_LEN, 16'd1472, largest legal payload length in bytes.
REQ-004 SHALL have port clk_15_625, in, 1, the single clock for all logic.
REQ-005 SHALL have port core_reset, in, 1, asynchronous active-high reset.
REQ-006 SHALL have ports chN_req, in, 1 (N=0,1), requester holds a complete packet in its FWFT source.
REQ-007 SHALL have ports chN_len, in, 16, payload length in bytes.
REQ-008 SHALL have ports chN_data, in, 64, current FWFT word.
REQ-009 SHALL have ports chN_rd, out, 1, pop strobe; the word is consumed in the same cycle.
REQ-010 SHALL have ports chN_done and chN_drop, out, 1 each, one-cycle packet outcome pulses.
REQ-011 SHALL have ports udp_tx_ready, app_tx_ack and dst_ip_unreachable, in, 1 each, UDP core status.
REQ-012 SHALL have ports app_tx_request, app_tx_data_valid and app_tx_data_last, out, 1 each.
REQ-013 SHALL have ports app_tx_data (out, 64), app_tx_data_keep (out, 8) and app_tx_data_length (out, 16).
REQ-014 SHALL have port busy, out, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, REQ, DATA and GAP.
REQ-016 IDLE SHALL move to REQ when udp_tx_ready=1 and any chN_req=1; the winner is chosen round-robin (opposite of last_gnt when both request), and gnt, len and beats=(len+7)>>3 are latched.
REQ-017 If the latched len is 0 or >MAX_LEN, the block SHALL pulse chN_drop, skip REQ, move to GAP and update last_gnt.
REQ-018 REQ SHALL hold app_tx_request=1 and app_tx_data_length=latched len until an outcome.
REQ-019 The REQ outcomes SHALL be: app_tx_ack -> DATA; dst_ip_unreachable -> chN_drop pulse, GAP; ACK_TIMEOUT cycles elapsed -> chN_drop pulse, GAP.
REQ-020 When app_tx_ack and dst_ip_unreachable are asserted in the same cycle, ack SHALL win.
REQ-021 app_tx_request SHALL be registered and SHALL deassert in the cycle after the outcome.
REQ-022 In DATA, app_tx_data_valid=1 every cycle, chN_rd(gnt)=app_tx_data_valid, and app_tx_data=chN_data(gnt) via a combinational mux.
REQ-023 In DATA, a beat counter SHALL run 0..beats-1, and app_tx_data_last=1 on beat beats-1.
REQ-024 app_tx_data_keep SHALL be 8'hFF except on the last beat, where it is the low len[2:0] bytes set (len[2:0]=0 -> 8'hFF).
REQ-025 The cycle after the last beat, the block SHALL pulse chN_done(gnt) and move to GAP.
REQ-026 The block SHALL set last_gnt=gnt on every outcome, whether done or drop.
REQ-027 GAP SHALL count GAP_CYCLES cycles and then return to IDLE; GAP_CYCLES=0 SHALL mean one GAP cycle.
REQ-028 Deassertion of chN_req after grant SHALL be ignored; the packet always completes or drops.
REQ-029 udp_tx_ready falling during REQ or DATA SHALL be ignored.
REQ-030 The REQ timeout and the GAP count SHALL share one 16-bit counter, cleared on every state entry.
REQ-031 The non-granted channel's chN_rd, chN_done and chN_drop SHALL stay 0.

Reset
REQ-032 core_reset SHALL asynchronously force IDLE; app_tx_request, app_tx_data_valid, app_tx_data_last, chN_rd, chN_done, chN_drop and busy to 0; app_tx_data_keep and app_tx_data_length to 0; counters to 0; last_gnt=1 so ch0 wins first.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no done or drop pulse.

Structure
REQ-034 Package udp_arb_pkg SHALL hold the state encoding, MAX_LEN default and beat-count width (8 bits).
REQ-035 The block SHALL be a single module with no sub-module; the 2-way round-robin is inline.

Verification
REQ-036 ch0 len=20, ack after 3 cycles -> request held 3 cycles, then 3 beats, keep FF, FF, 0F, last on beat 3, ch0_done pulse, GAP_CYCLES idle.
REQ-037 ch0 and ch1 requesting continuously with len=8 -> grants alternate ch0, ch1, ch0, ch1, one beat each, keep=FF.
REQ-038 dst_ip_unreachable in REQ -> ch1_drop pulse, no data_valid, GAP entered; ack+unreachable in the same cycle -> DATA.
REQ-039 No ack for ACK_TIMEOUT=100 cycles -> request drops at cycle 101 and a drop pulse is issued; len=0 or len=1500 -> immediate drop, app_tx_request never asserted.
REQ-040 core_reset during beat 2 of 5 -> all outputs 0 at once, no done pulse; after release ch0 wins first.
